ex_mem_pipe: RTL and testbench

//  Parametrised EX->MEM pipeline register with valid/ready handshake, 2-entry skid buffer,

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/skid_buffer.sv | 56 +++++
 rtl/ex_mem_pipe.sv | 74 +++++++
 tb/tb_ex_mem_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath widths, memory-op encodings and the EX/MEM payload.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int MOP_W = 4;

  typedef enum logic [MOP_W-1:0] {
    MOP_NONE = 4'd0,
    MOP_LB   = 4'd1,
    MOP_LH   = 4'd2,
    MOP_LW   = 4'd3,
    MOP_LBU  = 4'd4,
    MOP_LHU  = 4'd5,
    MOP_SB   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SW   = 4'd8
  } mem_op_e;

  typedef struct packed {
    logic [RA_W-1:0]  wd;
    logic             wreg;
    logic [XLEN-1:0]  wdata;
    logic [MOP_W-1:0] mem_op;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  store_data;
  } ex_mem_pkt_t;

  // x0 is hard-wired to zero, so writes to it must never be forwarded
  function automatic logic fwd_tag_ok(input logic [RA_W-1:0] wd);
    return (wd != {RA_W{1'b0}});
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush; in_ready is a pure register.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         m_valid_r;
  logic         s_valid_r;
  logic [W-1:0] m_data_r;
  logic [W-1:0] s_data_r;
  logic         accept_s;
  logic         consume_s;

  assign in_ready  = ~s_valid_r;
  assign accept_s  = in_valid & ~s_valid_r;
  assign consume_s = m_valid_r & out_ready;
  assign out_valid = m_valid_r;
  assign out_data  = m_data_r;

  // Main/skid entry update: S only fills while M stalls, and always drains into M first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      s_valid_r <= 1'b0;
      m_data_r  <= {W{1'b0}};
      s_data_r  <= {W{1'b0}};
    end else if (flush) begin
      m_valid_r <= 1'b0;
      s_valid_r <= 1'b0;
    end else if (!m_valid_r || consume_s) begin
      if (s_valid_r) begin
        m_valid_r <= 1'b1;
        m_data_r  <= s_data_r;
        s_valid_r <= 1'b0;
      end else begin
        m_valid_r <= accept_s;
        if (accept_s) begin
          m_data_r <= in_data;
        end
      end
    end else if (accept_s) begin
      s_valid_r <= 1'b1;
      s_data_r  <= in_data;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register: packs the EX payload into a skid buffer and gates the
// side-effecting fields (write-back, memory op, bypass) with the output valid.
module ex_mem_pipe #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int RA_W  = riscv_pkg::RA_W,
  parameter int MOP_W = riscv_pkg::MOP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [RA_W-1:0]  ex_wd,
  input  logic             ex_wreg,
  input  logic [XLEN-1:0]  ex_wdata,
  input  logic [MOP_W-1:0] ex_mem_op,
  input  logic [XLEN-1:0]  ex_mem_addr,
  input  logic [XLEN-1:0]  ex_store_data,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [RA_W-1:0]  mem_wd,
  output logic             mem_wreg,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [MOP_W-1:0] mem_mem_op,
  output logic [XLEN-1:0]  mem_mem_addr,
  output logic [XLEN-1:0]  mem_store_data,
  output logic             fwd_valid,
  output logic [RA_W-1:0]  fwd_wd,
  output logic [XLEN-1:0]  fwd_wdata
);

  riscv_pkg::ex_mem_pkt_t in_pkt_s;
  riscv_pkg::ex_mem_pkt_t out_pkt_s;
  logic                   out_valid_s;

  // Pack the EX-side fields into the stored payload
  always_comb begin
    in_pkt_s            = '{default: 1'b0};
    in_pkt_s.wd         = ex_wd;
    in_pkt_s.wreg       = ex_wreg;
    in_pkt_s.wdata      = ex_wdata;
    in_pkt_s.mem_op     = ex_mem_op;
    in_pkt_s.mem_addr   = ex_mem_addr;
    in_pkt_s.store_data = ex_store_data;
  end

  skid_buffer #(
    .W($bits(riscv_pkg::ex_mem_pkt_t))
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (ex_valid),
    .in_ready (ex_ready),
    .in_data  (in_pkt_s),
    .out_valid(out_valid_s),
    .out_ready(mem_ready),
    .out_data (out_pkt_s)
  );

  // Stale payload left behind by a flush must not cause a write, access or bypass
  assign mem_valid      = out_valid_s;
  assign mem_wd         = out_pkt_s.wd;
  assign mem_wreg       = out_pkt_s.wreg & out_valid_s;
  assign mem_wdata      = out_pkt_s.wdata;
  assign mem_mem_op     = out_valid_s ? out_pkt_s.mem_op : {MOP_W{1'b0}};
  assign mem_mem_addr   = out_pkt_s.mem_addr;
  assign mem_store_data = out_pkt_s.store_data;

  assign fwd_valid = mem_valid & mem_wreg & riscv_pkg::fwd_tag_ok(out_pkt_s.wd);
  assign fwd_wd    = out_pkt_s.wd;
  assign fwd_wdata = out_pkt_s.wdata;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: a FIFO model of held entries, directed scenarios
// followed by randomized valid/ready/flush traffic.
module tb_ex_mem_pipe;
  import riscv_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             ex_valid;
  logic             ex_ready;
  logic [RA_W-1:0]  ex_wd;
  logic             ex_wreg;
  logic [XLEN-1:0]  ex_wdata;
  logic [MOP_W-1:0] ex_mem_op;
  logic [XLEN-1:0]  ex_mem_addr;
  logic [XLEN-1:0]  ex_store_data;
  logic             mem_valid;
  logic             mem_ready;
  logic [RA_W-1:0]  mem_wd;
  logic             mem_wreg;
  logic [XLEN-1:0]  mem_wdata;
  logic [MOP_W-1:0] mem_mem_op;
  logic [XLEN-1:0]  mem_mem_addr;
  logic [XLEN-1:0]  mem_store_data;
  logic             fwd_valid;
  logic [RA_W-1:0]  fwd_wd;
  logic [XLEN-1:0]  fwd_wdata;

  ex_mem_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_mem_op(mem_mem_op), .mem_mem_addr(mem_mem_addr), .mem_store_data(mem_store_data),
    .fwd_valid(fwd_valid), .fwd_wd(fwd_wd), .fwd_wdata(fwd_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  ex_mem_pkt_t sb_q[$];
  int          held = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic ex_mem_pkt_t mk_pkt(input logic [RA_W-1:0] wd, input logic wreg,
                                         input logic [XLEN-1:0] wdata);
    ex_mem_pkt_t p;
    p.wd         = wd;
    p.wreg       = wreg;
    p.wdata      = wdata;
    p.mem_op     = MOP_W'($urandom_range(0, 8));
    p.mem_addr   = $urandom;
    p.store_data = $urandom;
    return p;
  endfunction

  function automatic ex_mem_pkt_t rand_pkt();
    return mk_pkt(RA_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
  endfunction

  // Drive one cycle of stimulus; the model holds every accepted, not yet consumed entry.
  task automatic step(input bit v, input bit rdy, input bit fl, input ex_mem_pkt_t p);
    @(negedge clk);
    ex_valid      = v;
    mem_ready     = rdy;
    flush         = fl;
    ex_wd         = p.wd;
    ex_wreg       = p.wreg;
    ex_wdata      = p.wdata;
    ex_mem_op     = p.mem_op;
    ex_mem_addr   = p.mem_addr;
    ex_store_data = p.store_data;
    held = sb_q.size();
    chk("ex_ready", 64'(ex_ready), 64'(held < 2));
    chk("mem_valid", 64'(mem_valid), 64'(held > 0));
    if (v && held < 2 && !fl) sb_q.push_back(p);
  endtask

  // Monitor: compare the presented entry with the oldest expected one; pop on consume
  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      if (held > 0 && sb_q.size() > 0) begin
        ex_mem_pkt_t e;
        e = sb_q[0];
        chk("mem_wd", 64'(mem_wd), 64'(e.wd));
        chk("mem_wreg", 64'(mem_wreg), 64'(e.wreg));
        chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
        chk("mem_mem_op", 64'(mem_mem_op), 64'(e.mem_op));
        chk("mem_mem_addr", 64'(mem_mem_addr), 64'(e.mem_addr));
        chk("mem_store_data", 64'(mem_store_data), 64'(e.store_data));
        chk("fwd_valid", 64'(fwd_valid), 64'(e.wreg && (e.wd != 0)));
        chk("fwd_wd", 64'(fwd_wd), 64'(e.wd));
        chk("fwd_wdata", 64'(fwd_wdata), 64'(e.wdata));
        if (mem_ready) e = sb_q.pop_front();
      end else begin
        chk("idle_mem_wreg", 64'(mem_wreg), 64'd0);
        chk("idle_mem_mem_op", 64'(mem_mem_op), 64'd0);
        chk("idle_fwd_valid", 64'(fwd_valid), 64'd0);
      end
      if (flush) sb_q.delete();
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
    chk({tag, "_ex_ready"}, 64'(ex_ready), 64'd1);
    chk({tag, "_mem_wreg"}, 64'(mem_wreg), 64'd0);
    chk({tag, "_mem_wd"}, 64'(mem_wd), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_mem_mem_op"}, 64'(mem_mem_op), 64'd0);
    chk({tag, "_mem_mem_addr"}, 64'(mem_mem_addr), 64'd0);
    chk({tag, "_mem_store_data"}, 64'(mem_store_data), 64'd0);
    chk({tag, "_fwd_valid"}, 64'(fwd_valid), 64'd0);
    chk({tag, "_fwd_wdata"}, 64'(fwd_wdata), 64'd0);
  endtask

  ex_mem_pkt_t idle_p;

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
    ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_mem_op = '0;
    ex_mem_addr = '0; ex_store_data = '0;
    idle_p = mk_pkt(5'd0, 1'b0, 32'd0);
    #3;
    chk_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, idle_p);

    // streaming 0x11..0x15 with MEM always ready
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, mk_pkt(5'd3, 1'b1, 32'h11 + 32'(i)));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, idle_p);

    // backpressure: A and B held, C refused until the stage drains
    step(1'b1, 1'b0, 1'b0, mk_pkt(5'd1, 1'b1, 32'hA));
    step(1'b1, 1'b0, 1'b0, mk_pkt(5'd2, 1'b1, 32'hB));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, mk_pkt(5'd4, 1'b1, 32'hEE));
    step(1'b0, 1'b1, 1'b0, idle_p);
    step(1'b0, 1'b1, 1'b0, idle_p);
    step(1'b1, 1'b1, 1'b0, mk_pkt(5'd5, 1'b1, 32'hC));
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, idle_p);

    // flush with both entries full and a new instruction offered
    step(1'b1, 1'b0, 1'b0, mk_pkt(5'd6, 1'b1, 32'h1));
    step(1'b1, 1'b0, 1'b0, mk_pkt(5'd7, 1'b1, 32'h2));
    step(1'b1, 1'b0, 1'b1, mk_pkt(5'd8, 1'b1, 32'h3));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, idle_p);

    // bypass tap: x7 forwarded, x0 never
    step(1'b1, 1'b0, 1'b0, mk_pkt(5'd7, 1'b1, 32'hDEAD));
    step(1'b0, 1'b0, 1'b0, idle_p);
    step(1'b0, 1'b1, 1'b0, idle_p);
    step(1'b1, 1'b0, 1'b0, mk_pkt(5'd0, 1'b1, 32'hBEEF));
    step(1'b0, 1'b1, 1'b0, idle_p);
    step(1'b0, 1'b1, 1'b0, idle_p);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 19) == 0), rand_pkt());
    end

    // async reset while stalled with the skid entry full
    step(1'b1, 1'b0, 1'b0, mk_pkt(5'd9, 1'b1, 32'h55));
    step(1'b1, 1'b0, 1'b0, mk_pkt(5'd10, 1'b1, 32'h66));
    step(1'b0, 1'b0, 1'b0, idle_p);
    @(negedge clk);
    mon_en = 1'b0;
    ex_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk_reset_state("async_reset");
    sb_q.delete();
    held = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, idle_p);
    step(1'b1, 1'b1, 1'b0, mk_pkt(5'd11, 1'b1, 32'h77));
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, idle_p);

    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
